// File: rtl/tt3_pkg.sv
// Shared constants and the per-character decode result for the typewriter translator.
// Pure declarations; no logic, no latency, no flow control.
package tt3_pkg;

  localparam logic [5:0] TT_SPACE   = 6'd36;
  localparam logic [5:0] TT_NOPRINT = 6'd62;
  localparam logic [5:0] TT_NEWLINE = 6'd63;

  localparam logic [7:0] E_NL = 8'h15;
  localparam logic [7:0] E_SP = 8'h40;
  localparam logic [7:0] E_a  = 8'h81;
  localparam logic [7:0] E_A  = 8'hC1;
  localparam logic [7:0] E_0  = 8'hF0;

  typedef struct packed {
    logic [5:0] code;
    logic       lc;
    logic       uc;
  } tt_res_t;

  localparam tt_res_t TT_RES_IDLE = '{code: TT_NOPRINT, lc: 1'b0, uc: 1'b0};

endpackage

// File: rtl/tt3_decode.sv
// EBCDIC byte to typewriter element code and case hemisphere; purely combinational.
// Zero latency, no backpressure: output follows the input byte.
module tt3_decode
  import tt3_pkg::*;
(
  input  logic [7:0] data,
  output tt_res_t    res
);

  logic [3:0] hi;
  logic [3:0] lo;
  logic       lo_1_9;

  assign hi     = data[7:4];
  assign lo     = data[3:0];
  assign lo_1_9 = (lo >= 4'd1) && (lo <= 4'd9);

  // Letter blocks share codes; hi[2] picks the upper-case rows (Cx/Dx/Ex).
  always_comb begin
    res = TT_RES_IDLE;
    if (lo_1_9 && (hi == E_a[7:4] || hi == E_A[7:4])) begin
      res.code = {2'b00, lo} - 6'd1;
      res.uc   = hi[2];
      res.lc   = ~hi[2];
    end else if (lo_1_9 && (hi == 4'h9 || hi == 4'hD)) begin
      res.code = {2'b00, lo} + 6'd8;
      res.uc   = hi[2];
      res.lc   = ~hi[2];
    end else if (lo >= 4'd2 && lo <= 4'd9 && (hi == 4'hA || hi == 4'hE)) begin
      res.code = {2'b00, lo} + 6'd16;
      res.uc   = hi[2];
      res.lc   = ~hi[2];
    end else if (hi == E_0[7:4] && lo <= 4'd9) begin
      res.code = {2'b00, lo} + 6'd26;
      res.lc   = 1'b1;
    end else begin
      case (data)
        E_SP:    res.code = TT_SPACE;
        E_NL:    res.code = TT_NEWLINE;
        8'h4B:   begin res.code = 6'd37; res.lc = 1'b1; end
        8'h6B:   begin res.code = 6'd38; res.lc = 1'b1; end
        8'h60:   begin res.code = 6'd39; res.lc = 1'b1; end
        8'h61:   begin res.code = 6'd40; res.lc = 1'b1; end
        8'h7E:   begin res.code = 6'd41; res.lc = 1'b1; end
        8'h7D:   begin res.code = 6'd42; res.lc = 1'b1; end
        8'h4D:   begin res.code = 6'd43; res.uc = 1'b1; end
        8'h5D:   begin res.code = 6'd44; res.uc = 1'b1; end
        8'h4E:   begin res.code = 6'd45; res.uc = 1'b1; end
        8'h5C:   begin res.code = 6'd46; res.uc = 1'b1; end
        default: res = TT_RES_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tt3.sv
// Console typewriter translator: decoded byte through a LATENCY-deep register pipeline.
// Latency LATENCY edges; no backpressure, the pipeline advances every cycle.
module tt3
  import tt3_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_data_reg,
  output logic [5:0] o_tt_out,
  output logic       o_lower_case_character,
  output logic       o_upper_case_character
);

  tt_res_t dec;
  tt_res_t pipe [0:LATENCY-1];

  tt3_decode u_decode (
    .data (i_data_reg),
    .res  (dec)
  );

  // Every stage clears asynchronously so in-flight characters are dropped at once.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= TT_RES_IDLE;
    end else begin
      pipe[0] <= dec;
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign o_tt_out               = pipe[LATENCY-1].code;
  assign o_lower_case_character = pipe[LATENCY-1].lc;
  assign o_upper_case_character = pipe[LATENCY-1].uc;

endmodule

// File: tb/tb_tt3.sv
// Directed bench: a LATENCY=3 and a LATENCY=1 instance share clock, reset and input byte.
module tb_tt3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data = 8'h00;

  logic [5:0] code3, code1;
  logic       lc3, uc3, lc1, uc1;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_val [256];
  bit         exp_set [256];

  always #5 clk = ~clk;

  tt3 #(.LATENCY(3)) dut3 (
    .i_clk(clk), .i_reset(rst_n), .i_data_reg(data),
    .o_tt_out(code3), .o_lower_case_character(lc3), .o_upper_case_character(uc3)
  );

  tt3 #(.LATENCY(1)) dut1 (
    .i_clk(clk), .i_reset(rst_n), .i_data_reg(data),
    .o_tt_out(code1), .o_lower_case_character(lc1), .o_upper_case_character(uc1)
  );

  function automatic logic [7:0] mk(input int code, input bit lc, input bit uc);
    logic [5:0] c;
    c = code[5:0];
    return {c, lc, uc};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got code=%0d lc=%b uc=%b, want code=%0d lc=%b uc=%b",
             tag, obs[7:2], obs[1], obs[0], exp[7:2], exp[1], exp[0]);
    end
  endtask

  task automatic set_exp(input logic [7:0] b, input int code, input bit lc, input bit uc);
    exp_val[b] = mk(code, lc, uc);
    exp_set[b] = 1'b1;
  endtask

  initial begin
    logic [7:0] idle;
    idle = mk(62, 0, 0);
    for (int i = 0; i < 256; i++) exp_set[i] = 1'b0;

    // Hand-computed decode table entries
    set_exp(8'h81, 0, 1, 0);   set_exp(8'hC1, 0, 0, 1);
    set_exp(8'h89, 8, 1, 0);   set_exp(8'hC9, 8, 0, 1);
    set_exp(8'h91, 9, 1, 0);   set_exp(8'h99, 17, 1, 0);
    set_exp(8'hD1, 9, 0, 1);   set_exp(8'hA2, 18, 1, 0);
    set_exp(8'hA9, 25, 1, 0);  set_exp(8'hE9, 25, 0, 1);
    set_exp(8'hE2, 18, 0, 1);
    set_exp(8'hF0, 26, 1, 0);  set_exp(8'hF9, 35, 1, 0);
    set_exp(8'h40, 36, 0, 0);  set_exp(8'h15, 63, 0, 0);
    set_exp(8'h00, 62, 0, 0);  set_exp(8'h8A, 62, 0, 0);
    set_exp(8'h90, 62, 0, 0);  set_exp(8'hA1, 62, 0, 0);
    set_exp(8'hC0, 62, 0, 0);  set_exp(8'hE1, 62, 0, 0);
    set_exp(8'hFA, 62, 0, 0);  set_exp(8'hFF, 62, 0, 0);
    set_exp(8'h4B, 37, 1, 0);  set_exp(8'h6B, 38, 1, 0);
    set_exp(8'h60, 39, 1, 0);  set_exp(8'h61, 40, 1, 0);
    set_exp(8'h7E, 41, 1, 0);  set_exp(8'h7D, 42, 1, 0);
    set_exp(8'h4D, 43, 0, 1);  set_exp(8'h5D, 44, 0, 1);
    set_exp(8'h4E, 45, 0, 1);  set_exp(8'h5C, 46, 0, 1);

    // 1: reset held with 'a' on the input, then release between edges
    data  = 8'h81;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_l3", {code3, lc3, uc3}, idle);
    chk("rst_l1", {code1, lc1, uc1}, idle);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_e1_l3", {code3, lc3, uc3}, idle);
    chk("rel_e1_l1", {code1, lc1, uc1}, mk(0, 1, 0));
    @(posedge clk); #1;
    chk("rel_e2_l3", {code3, lc3, uc3}, idle);
    @(posedge clk); #1;
    chk("rel_e3_l3", {code3, lc3, uc3}, mk(0, 1, 0));

    // 2-4: full sweep, one byte per cycle; L3 output trails by two further edges
    for (int i = 0; i < 258; i++) begin
      data = (i < 256) ? i[7:0] : 8'h00;
      @(posedge clk); #1;
      tests++;
      assert (!(lc3 && uc3) && !(lc1 && uc1)) else begin
        fails++;
        $error("FAIL excl at step %0d: lc3=%b uc3=%b lc1=%b uc1=%b, want never both set",
               i, lc3, uc3, lc1, uc1);
      end
      if (i < 256 && exp_set[i])
        chk($sformatf("sweep_l1_%02h", i[7:0]), {code1, lc1, uc1}, exp_val[i]);
      if (i >= 2 && exp_set[i-2])
        chk($sformatf("sweep_l3_%02h", 8'(i-2)), {code3, lc3, uc3}, exp_val[i-2]);
    end

    // 5: reset dropped mid-stream, checked between clock edges
    data = 8'h81; @(posedge clk); #1;
    data = 8'h82; @(posedge clk); #1;
    data = 8'h83; @(posedge clk); #1;
    chk("pre_drop_l3", {code3, lc3, uc3}, mk(0, 1, 0));
    #2 rst_n = 1'b0;
    #1;
    chk("drop_l3", {code3, lc3, uc3}, idle);
    chk("drop_l1", {code1, lc1, uc1}, idle);
    data = 8'hC1;
    @(posedge clk); #1;
    chk("held_l3", {code3, lc3, uc3}, idle);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel2_e1_l3", {code3, lc3, uc3}, idle);
    @(posedge clk); #1;
    chk("rel2_e2_l3", {code3, lc3, uc3}, idle);
    @(posedge clk); #1;
    chk("rel2_e3_l3", {code3, lc3, uc3}, mk(0, 0, 1));

    // 6: LATENCY=1 single edge and alternating case
    data = 8'h40;
    @(posedge clk); #1;
    chk("space_l1", {code1, lc1, uc1}, mk(36, 0, 0));
    for (int i = 0; i < 6; i++) begin
      data = i[0] ? 8'hC1 : 8'h81;
      @(posedge clk); #1;
      chk($sformatf("alt_l1_%0d", i), {code1, lc1, uc1}, i[0] ? mk(0, 0, 1) : mk(0, 1, 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tt3.md
Name: tt3

Overview:
- Translates an 8-bit EBCDIC data-register byte into a 6-bit typewriter element code plus upper-case and lower-case shift indications.
- Sits between the console data register and the printer-mechanism driver of the console typewriter path.
- The decode itself is combinational.
- The result is delivered through a configurable-depth register pipeline.

Parameters:
- LATENCY, default 1: number of register stages from i_data_reg to the outputs. Legal range 1..8. The system instance uses 3.

Ports:
- i_clk  input  1  system clock; all registers on rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_data_reg  input  8  EBCDIC character to translate; sampled every cycle, no handshake.
- o_tt_out  output  6  element/function code.
- o_lower_case_character  output  1  character prints in lower-case hemisphere.
- o_upper_case_character  output  1  character prints in upper-case hemisphere.

Behaviour:
- Reset:
  - While i_reset=0, every pipeline stage is cleared asynchronously.
  - Cleared outputs: o_tt_out=6'h3E, lower=0, upper=0.
  - Release is synchronous to the next rising edge. Stages then fill normally.
  - Outputs show the reset value until LATENCY edges after release.
- Latency:
  - The decode of the byte present before rising edge N appears on the outputs after edge N+LATENCY-1.
  - Example: LATENCY=1 means registered on one edge; LATENCY=3 means visible after the third edge.
  - Pipeline advances every cycle; no stall or enable.
- Decode table (hex input -> o_tt_out, case):
  - a..i 81..89 -> 0..8, lower. j..r 91..99 -> 9..17, lower. s..z A2..A9 -> 18..25, lower.
  - A..I C1..C9, J..R D1..D9, S..Z E2..E9 -> same codes 0..25, upper.
  - 0..9 F0..F9 -> 26..35, lower.
  - space 40 -> 36, neither case bit.
  - '.' 4B -> 37, lower. ',' 6B -> 38, lower. '-' 60 -> 39, lower. '/' 61 -> 40, lower.
  - '=' 7E -> 41, lower. quote 7D -> 42, lower.
  - '(' 4D -> 43, upper. ')' 5D -> 44, upper. '+' 4E -> 45, upper. '*' 5C -> 46, upper.
  - NL 15 -> 63 (function code), neither case bit.
  - Every other byte, including gaps such as 8A..90, A1, C0 and FA..FF -> 62 (no-print), neither case bit.
- Case bits: upper and lower are never both 1.
- Boundaries:
  - Byte changing every cycle yields one independent result per cycle, in order, with no loss or merging.
  - Reset asserted mid-stream discards all in-flight results immediately.

Decomposition:
- Package tt3_pkg holds:
  - constants TT_SPACE=36, TT_NOPRINT=62, TT_NEWLINE=63;
  - EBCDIC constants E_NL=8'h15, E_SP=8'h40, E_a=8'h81, E_A=8'hC1, E_0=8'hF0;
  - a packed struct {code[5:0], lc, uc} for one decode result.
- One combinational sub-module tt3_decode (byte in, struct out) holding the table.
- tt3 is the LATENCY-deep pipeline around tt3_decode.

Test Plan:
1. Hold i_reset=0 with i_data_reg=8'h81 -> o_tt_out=3E, lc=0, uc=0. After release with LATENCY=3: unchanged after edges 1-2, then 0 with lc=1 after edge 3.
2. Sweep 00..FF, one byte per cycle, LATENCY=3 -> each output trails its input by 3 cycles. Spot checks:
   - 81 -> 00/lc; C1 -> 00/uc; A9 -> 25/lc; E9 -> 25/uc;
   - F0 -> 26/lc; F9 -> 35/lc;
   - 40 -> 36/none; 15 -> 63/none.
3. Unmapped bytes 00, 8A, A1, C0, FF -> code 62, lc=uc=0. Across the full sweep lc&uc is never 1.
4. Punctuation: 4B -> 37/lc, 4D -> 43/uc, 5C -> 46/uc, 7E -> 41/lc.
5. Drop i_reset to 0 mid-sweep -> outputs go to 3E/0/0 without waiting for a clock edge. After release the first new result appears LATENCY edges later.
6. LATENCY=1 build: byte 8'h40 -> 36 after one edge. Alternate 81/C1 every cycle -> lc and uc alternate each cycle.
